// File: rtl/cache_arbiter.sv
// Two-port round-robin arbiter sharing one L2 port between the icache and dcache.
// The FSM state doubles as the grant; last_winner breaks ties when both sides request.
module cache_arbiter #(
    parameter logic RESET_PRIO = 1'b1  // side that wins the first tie after reset: 1 = dcache, 0 = icache
) (
    input  logic         clk,
    input  logic         rst,

    input  logic [31:0]  icache_address,
    input  logic [255:0] icache_wdata,
    input  logic         icache_read,
    input  logic         icache_write,
    output logic         icache_resp,
    output logic [255:0] icache_rdata,

    input  logic [31:0]  dcache_address,
    input  logic [255:0] dcache_wdata,
    input  logic         dcache_read,
    input  logic         dcache_write,
    output logic         dcache_resp,
    output logic [255:0] dcache_rdata,

    output logic [31:0]  mem_address,
    output logic [255:0] mem_wdata,
    output logic         mem_read,
    output logic         mem_write,
    input  logic         mem_resp,
    input  logic [255:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state, state_next;
    logic   last_winner, last_winner_next;  // 1 = dcache won the most recent grant

    logic i_req, d_req;

    assign i_req = icache_read | icache_write;
    assign d_req = dcache_read | dcache_write;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_winner <= ~RESET_PRIO;
        end else begin
            state       <= state_next;
            last_winner <= last_winner_next;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next       = state;
        last_winner_next = last_winner;
        case (state)
            IDLE: begin
                if (i_req && (!d_req || last_winner)) begin
                    state_next       = SERVE_I;
                    last_winner_next = 1'b0;
                end else if (d_req) begin
                    state_next       = SERVE_D;
                    last_winner_next = 1'b1;
                end
            end
            // A granted side that drops its strobe early is still held until L2 answers.
            SERVE_I: if (mem_resp) state_next = IDLE;
            SERVE_D: if (mem_resp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_address = '0;
        mem_wdata   = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        icache_resp = 1'b0;
        dcache_resp = 1'b0;
        case (state)
            SERVE_I: begin
                mem_address = icache_address;
                mem_wdata   = icache_wdata;
                mem_write   = icache_write;
                mem_read    = icache_read & ~icache_write;  // write takes precedence
                icache_resp = mem_resp;
            end
            SERVE_D: begin
                mem_address = dcache_address;
                mem_wdata   = dcache_wdata;
                mem_write   = dcache_write;
                mem_read    = dcache_read & ~dcache_write;
                dcache_resp = mem_resp;
            end
            default: ;
        endcase
    end

    assign icache_rdata = mem_rdata;
    assign dcache_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: per-cycle vector table, reset corner cases,
// and a queue scoreboard for sustained two-sided traffic.
module tb_cache_arbiter;

    localparam logic [31:0]  I_ADDR = 32'h0000_0060;
    localparam logic [31:0]  D_ADDR = 32'h0000_1000;
    localparam logic [255:0] WI     = {8{32'h1111_0001}};
    localparam logic [255:0] WD     = {8{32'hD00D_BEEF}};
    localparam logic [255:0] PAT_A  = {8{32'hA5A5_5A5A}};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  icache_address = I_ADDR;
    logic [255:0] icache_wdata   = WI;
    logic         icache_read    = 1'b0;
    logic         icache_write   = 1'b0;
    logic         icache_resp;
    logic [255:0] icache_rdata;
    logic [31:0]  dcache_address = D_ADDR;
    logic [255:0] dcache_wdata   = WD;
    logic         dcache_read    = 1'b0;
    logic         dcache_write   = 1'b0;
    logic         dcache_resp;
    logic [255:0] dcache_rdata;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic         mem_read;
    logic         mem_write;
    logic         mem_resp       = 1'b0;
    logic [255:0] mem_rdata      = PAT_A;

    cache_arbiter #(.RESET_PRIO(1'b1)) dut (
        .clk(clk), .rst(rst),
        .icache_address(icache_address), .icache_wdata(icache_wdata),
        .icache_read(icache_read), .icache_write(icache_write),
        .icache_resp(icache_resp), .icache_rdata(icache_rdata),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_resp(dcache_resp), .dcache_rdata(dcache_rdata),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_passed = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_rd_wr"}, {254'd0, mem_read, mem_write}, 256'd0);
        check({name, "_addr"}, {224'd0, mem_address}, 256'd0);
        check({name, "_wdata"}, mem_wdata, 256'd0);
        check({name, "_resp"}, {254'd0, icache_resp, dcache_resp}, 256'd0);
    endtask

    task automatic clear_inputs();
        icache_read  = 1'b0;
        icache_write = 1'b0;
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        mem_resp     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        icache_address = I_ADDR;
        icache_wdata   = WI;
        dcache_address = D_ADDR;
        dcache_wdata   = WD;
        mem_rdata      = PAT_A;
        rst = 1'b1;
        @(negedge clk);
        #1 check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One row is one clock cycle: inputs applied after the falling edge, outputs checked 1 ns later.
    // grant: 0 = nobody on the L2 port, 1 = icache mirrored, 2 = dcache mirrored.
    typedef struct {
        bit       rst_before;
        bit       i_rd, i_wr, d_rd, d_wr, m_resp;
        bit [1:0] grant;
        bit       e_rd, e_wr, e_iresp, e_dresp;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input bit rb, input bit ir, input bit iw, input bit dr, input bit dw,
                       input bit mr, input bit [1:0] g, input bit erd, input bit ewr,
                       input bit eir, input bit edr);
        vec_t v;
        v.rst_before = rb;
        v.i_rd = ir; v.i_wr = iw; v.d_rd = dr; v.d_wr = dw; v.m_resp = mr;
        v.grant = g; v.e_rd = erd; v.e_wr = ewr; v.e_iresp = eir; v.e_dresp = edr;
        vecs.push_back(v);
    endtask

    typedef struct {
        bit           side;  // 1 = dcache
        logic [31:0]  addr;
        bit           wr;
        logic [255:0] wdata;
    } sb_t;

    sb_t sb_q[$];

    initial begin
        // Single icache read, L2 answers on the fifth serve cycle.
        row(1, 1,0,0,0,0, 0, 0,0,0,0);
        for (int k = 0; k < 4; k++) row(0, 1,0,0,0,0, 1, 1,0,0,0);
        row(0, 1,0,0,0,1, 1, 1,0,1,0);
        row(0, 0,0,0,0,0, 0, 0,0,0,0);
        // Tie after reset goes to dcache; the next tie goes to icache.
        row(1, 1,0,0,1,0, 0, 0,0,0,0);
        row(0, 1,0,0,1,0, 2, 0,1,0,0);
        row(0, 1,0,0,1,1, 2, 0,1,0,1);
        row(0, 1,0,0,1,0, 0, 0,0,0,0);
        row(0, 1,0,0,1,0, 1, 1,0,0,0);
        row(0, 1,0,0,1,1, 1, 1,0,1,0);
        row(0, 0,0,0,1,0, 0, 0,0,0,0);
        row(0, 0,0,0,1,1, 2, 0,1,0,1);
        row(0, 0,0,0,0,0, 0, 0,0,0,0);
        // Read and write together forward as a write.
        row(0, 0,0,1,1,0, 0, 0,0,0,0);
        row(0, 0,0,1,1,0, 2, 0,1,0,0);
        row(0, 0,0,1,1,1, 2, 0,1,0,1);
        row(0, 0,0,0,0,0, 0, 0,0,0,0);
        // Stray L2 responses in IDLE are ignored, even with a request pending.
        row(0, 0,0,0,0,1, 0, 0,0,0,0);
        row(0, 1,0,0,0,1, 0, 0,0,0,0);
        row(0, 1,0,0,0,0, 1, 1,0,0,0);
        // Granted side drops its strobe early; the grant stays until mem_resp.
        row(0, 0,0,0,0,0, 1, 0,0,0,0);
        row(0, 0,0,0,0,1, 1, 0,0,1,0);
        row(0, 0,0,0,0,0, 0, 0,0,0,0);

        foreach (vecs[n]) begin
            vec_t v;
            logic [31:0]  ea;
            logic [255:0] ew;
            v = vecs[n];
            if (v.rst_before) do_reset();
            @(negedge clk);
            icache_read  = v.i_rd;
            icache_write = v.i_wr;
            dcache_read  = v.d_rd;
            dcache_write = v.d_wr;
            mem_resp     = v.m_resp;
            ea = (v.grant == 2'd1) ? I_ADDR : (v.grant == 2'd2) ? D_ADDR : 32'd0;
            ew = (v.grant == 2'd1) ? WI     : (v.grant == 2'd2) ? WD     : 256'd0;
            #1;
            check($sformatf("vec%0d_mem_read", n), {255'd0, mem_read}, {255'd0, v.e_rd});
            check($sformatf("vec%0d_mem_write", n), {255'd0, mem_write}, {255'd0, v.e_wr});
            check($sformatf("vec%0d_mem_address", n), {224'd0, mem_address}, {224'd0, ea});
            check($sformatf("vec%0d_mem_wdata", n), mem_wdata, ew);
            check($sformatf("vec%0d_icache_resp", n), {255'd0, icache_resp}, {255'd0, v.e_iresp});
            check($sformatf("vec%0d_dcache_resp", n), {255'd0, dcache_resp}, {255'd0, v.e_dresp});
            if (v.e_iresp) check($sformatf("vec%0d_icache_rdata", n), icache_rdata, PAT_A);
            if (v.e_dresp) check($sformatf("vec%0d_dcache_rdata", n), dcache_rdata, PAT_A);
        end

        // Reset in the middle of a dcache transaction, then a stray response for it.
        do_reset();
        @(negedge clk);
        dcache_read = 1'b1;
        @(negedge clk);
        #1 check("midrst_serving", {255'd0, mem_read}, 256'd1);
        #2 rst = 1'b1;
        #1 check_idle_outputs("midrst_async");
        @(negedge clk);
        rst = 1'b0;
        dcache_read = 1'b0;
        mem_resp = 1'b1;
        #1 check_idle_outputs("midrst_stray");
        // A request present while reset releases is granted on the first rising edge.
        @(negedge clk);
        mem_resp = 1'b0;
        rst = 1'b1;
        icache_read = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 check("rel_idle", {255'd0, mem_read}, 256'd0);
        @(negedge clk);
        #1 check("rel_grant_read", {255'd0, mem_read}, 256'd1);
        check("rel_grant_addr", {224'd0, mem_address}, {224'd0, I_ADDR});
        @(negedge clk);
        mem_resp = 1'b1;
        #1 check("rel_iresp", {254'd0, icache_resp, dcache_resp}, 256'd2);
        @(negedge clk);
        clear_inputs();

        // Both sides requesting back to back: service order must follow request order.
        do_reset();
        begin
            int  done = 0, lat = 0, cyc = 0, ni = 0, nd = 0;
            bit  busy = 1'b0, cur = 1'b0, prev_resp = 1'b0;
            sb_t e;
            @(negedge clk);
            icache_address = 32'h0000_0100;
            icache_read    = 1'b1;
            dcache_address = 32'h0000_2000;
            dcache_wdata   = {8{32'h0000_2000}};
            dcache_write   = 1'b1;
            sb_q.push_back('{1'b1, dcache_address, 1'b1, dcache_wdata});
            sb_q.push_back('{1'b0, icache_address, 1'b0, 256'd0});
            while (done < 10 && cyc < 400) begin
                @(negedge clk);
                cyc++;
                mem_resp  = busy && (lat == 0);
                mem_rdata = {8{cyc}};
                if (busy && lat > 0) lat--;
                #1;
                if (mem_resp) begin
                    check(cur ? "alt_dresp" : "alt_iresp", {254'd0, icache_resp, dcache_resp},
                          cur ? 256'd1 : 256'd2);
                    check("alt_rdata", cur ? dcache_rdata : icache_rdata, mem_rdata);
                    busy = 1'b0;
                    prev_resp = 1'b1;
                    done++;
                    if (cur) begin
                        nd++;
                        dcache_address = 32'h0000_2000 + 32'(nd * 32);
                        dcache_wdata   = {8{dcache_address}};
                        sb_q.push_back('{1'b1, dcache_address, 1'b1, dcache_wdata});
                    end else begin
                        ni++;
                        icache_address = 32'h0000_0100 + 32'(ni * 32);
                        sb_q.push_back('{1'b0, icache_address, 1'b0, 256'd0});
                    end
                end else begin
                    check("alt_no_resp", {254'd0, icache_resp, dcache_resp}, 256'd0);
                    if (prev_resp) begin
                        check("alt_turnaround", {254'd0, mem_read, mem_write}, 256'd0);
                        prev_resp = 1'b0;
                    end else if (!busy && (mem_read || mem_write)) begin
                        e = sb_q.pop_front();
                        check("alt_grant_addr", {224'd0, mem_address}, {224'd0, e.addr});
                        check("alt_grant_rw", {254'd0, mem_read, mem_write},
                              e.wr ? 256'd1 : 256'd2);
                        if (e.wr) check("alt_grant_wdata", mem_wdata, e.wdata);
                        busy = 1'b1;
                        cur  = e.side;
                        lat  = int'($urandom_range(0, 3));
                    end
                end
            end
            check("alt_completed", 256'(done), 256'd10);
        end
        @(negedge clk);
        clear_inputs();
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: RESET_PRIO, default 1'b1, tie-break winner for the first simultaneous request after reset (1 = dcache, 0 = icache).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 icache_address  input  32  I-side line address (rv32i_word).
REQ-005 icache_wdata  input  256  I-side write line (unused by icache, routed regardless).
REQ-006 icache_read / icache_write  input  1 each  I-side request strobes, held until icache_resp.
REQ-007 icache_resp  output  1  one-cycle completion pulse to I-side.
REQ-008 icache_rdata  output  256  line returned to I-side.
REQ-009 dcache_address / dcache_wdata / dcache_read / dcache_write  input  32/256/1/1  D-side request, same rules as I-side.
REQ-010 dcache_resp / dcache_rdata  output  1/256  D-side completion and line.
REQ-011 mem_address / mem_wdata / mem_read / mem_write  output  32/256/1/1  request to the shared L2.
REQ-012 mem_resp / mem_rdata  input  1/256  L2 completion pulse and line.

Function
REQ-013 FSM states SHALL be IDLE, SERVE_I, SERVE_D; state, grant and last-winner held in flops.
REQ-014 IDLE: no request -> stay IDLE; only icache requesting -> SERVE_I; only dcache -> SERVE_D; both -> requester not equal to last-winner (round-robin), last-winner updated on entry.
REQ-015 A requester is "requesting" when its read or write is high; read and write both high SHALL be forwarded as write only (mem_read forced 0).
REQ-016 SERVE_x: mem_address, mem_wdata, mem_read, mem_write SHALL combinationally mirror requester x; other requester sees resp 0.
REQ-017 IDLE: mem_read = mem_write = 0, mem_address = 0, mem_wdata = 0.
REQ-018 SERVE_x with mem_resp = 1: x_resp = 1 same cycle (combinational), next state IDLE.
REQ-019 mem_rdata SHALL drive both icache_rdata and dcache_rdata unconditionally; validity is qualified only by the respective resp.
REQ-020 mem_resp in IDLE SHALL be ignored (no resp to either side, no state change).
REQ-021 Minimum turnaround: one IDLE cycle between consecutive grants; back-to-back service of the waiting requester begins the cycle after the IDLE cycle in which it is seen.
REQ-022 Granted requester dropping read/write before mem_resp (protocol violation) SHALL NOT abort: arbiter stays in SERVE_x until mem_resp.
REQ-023 Losing requester waits with request held; no request lost, no starvation: each requester waits at most one other transaction.
REQ-024 Arbiter adds zero cycles of request latency beyond the IDLE decision cycle; L2 latency unbounded.

Reset
REQ-025 rst high SHALL asynchronously force state IDLE, last-winner = ~RESET_PRIO (so RESET_PRIO side wins first tie), all outputs per REQ-017 and icache_resp = dcache_resp = 0.
REQ-026 rst asserted mid-transaction SHALL abandon it; a later mem_resp for it is ignored per REQ-020.
REQ-027 First request after rst deassert SHALL be arbitrated on the first rising edge with rst low.

Verification
REQ-028 icache_read=1, addr 0x0000_0060, L2 resp after 5 cycles with rdata pattern A -> mem_read=1 addr 0x60 for 5 cycles, icache_resp one cycle, icache_rdata=A, dcache_resp stays 0.
REQ-029 After reset, icache_read and dcache_write (addr 0x0000_1000) rise same cycle -> dcache served first (mem_write=1, addr 0x1000), then IDLE one cycle, then icache served; next simultaneous tie goes to icache.
REQ-030 Continuous requests from both sides for 10 transactions -> grants alternate I/D strictly, no resp on wrong side.
REQ-031 rst pulsed during SERVE_D, then stray mem_resp -> all outputs 0 immediately on rst, stray resp produces no dcache_resp/icache_resp.
REQ-032 dcache_read and dcache_write both 1 -> mem_write=1, mem_read=0, dcache_wdata forwarded.
REQ-033 mem_resp pulsed while both sides idle -> no resp outputs, state remains IDLE.
